// File: rtl/audio_mixer.sv
// N-channel stereo mixer: per-channel Q1.7 gain, time-multiplexed MAC,
// saturating output with clip and overrun reporting.
module audio_mixer #(
    parameter int                      NUM_CHANNELS = 4,
    parameter int                      IN_WIDTH     = 16,
    parameter int                      OUT_WIDTH    = 16,
    parameter logic [NUM_CHANNELS-1:0] CH_SIGNED    = '0,
    parameter bit                      OUT_SIGNED   = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sample_strobe_i,
    input  logic [NUM_CHANNELS*IN_WIDTH-1:0] ch_l_i,
    input  logic [NUM_CHANNELS*IN_WIDTH-1:0] ch_r_i,
    input  logic [NUM_CHANNELS*8-1:0]        gain_i,
    input  logic                             mute_i,
    input  logic                             overrun_clr_i,
    output logic [OUT_WIDTH-1:0]             audio_l_o,
    output logic [OUT_WIDTH-1:0]             audio_r_o,
    output logic                             sample_valid_o,
    output logic                             clip_l_o,
    output logic                             clip_r_o,
    output logic                             busy_o,
    output logic                             overrun_o
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int P_W   = IN_WIDTH + 9;
    localparam int ACC_W = P_W + $clog2(NUM_CHANNELS);
    localparam int SH    = OUT_WIDTH - IN_WIDTH;
    localparam int R_W   = ACC_W - 7 + SH;
    localparam int CH_W  = NUM_CHANNELS * IN_WIDTH;

    localparam logic [IDX_W-1:0]     LAST    = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [OUT_WIDTH-1:0] MSB_O   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] SILENCE = OUT_SIGNED ? '0 : MSB_O;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_l_q, acc_r_q;
    logic [CH_W-1:0]          snap_l_q, snap_r_q;
    logic [NUM_CHANNELS*8-1:0] snap_g_q;
    logic                     snap_mute_q;

    logic [IN_WIDTH-1:0]        raw_l, raw_r, flip;
    logic [7:0]                 g;
    logic signed [IN_WIDTH-1:0] s_l, s_r;
    logic signed [8:0]          g9;
    logic signed [P_W-1:0]      prod_l, prod_r;

    logic signed [R_W-1:0]  r_l, r_r;
    logic [OUT_WIDTH:0]     sat_l, sat_r;
    logic [OUT_WIDTH-1:0]   out_l, out_r;
    logic                   clip_l, clip_r;

    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [R_W-1:0] r);
        logic [R_W-OUT_WIDTH:0] hi;
        hi = r[R_W-1:OUT_WIDTH-1];
        if (hi == '0 || hi == '1)
            saturate = {1'b0, r[OUT_WIDTH-1:0]};
        else if (r[R_W-1])
            saturate = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            saturate = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    // Offset-binary channels become two's complement by flipping the MSB
    always_comb begin
        raw_l  = snap_l_q[idx_q*IN_WIDTH +: IN_WIDTH];
        raw_r  = snap_r_q[idx_q*IN_WIDTH +: IN_WIDTH];
        g      = snap_g_q[idx_q*8 +: 8];
        flip   = {~CH_SIGNED[idx_q], {(IN_WIDTH-1){1'b0}}};
        s_l    = raw_l ^ flip;
        s_r    = raw_r ^ flip;
        g9     = {1'b0, g};
        prod_l = P_W'(s_l) * P_W'(g9);
        prod_r = P_W'(s_r) * P_W'(g9);
    end

    always_comb begin
        r_l   = R_W'(signed'(acc_l_q[ACC_W-1:7])) <<< SH;
        r_r   = R_W'(signed'(acc_r_q[ACC_W-1:7])) <<< SH;
        sat_l = saturate(r_l);
        sat_r = saturate(r_r);
        out_l  = sat_l[OUT_WIDTH-1:0];
        out_r  = sat_r[OUT_WIDTH-1:0];
        clip_l = sat_l[OUT_WIDTH];
        clip_r = sat_r[OUT_WIDTH];
        if (snap_mute_q) begin
            out_l  = '0;
            out_r  = '0;
            clip_l = 1'b0;
            clip_r = 1'b0;
        end
        if (!OUT_SIGNED) begin
            out_l = out_l ^ MSB_O;
            out_r = out_r ^ MSB_O;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (sample_strobe_i) state_d = S_ACCUM;
            S_ACCUM: if (idx_q == LAST) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            acc_l_q        <= '0;
            acc_r_q        <= '0;
            snap_l_q       <= '0;
            snap_r_q       <= '0;
            snap_g_q       <= '0;
            snap_mute_q    <= 1'b0;
            audio_l_o      <= SILENCE;
            audio_r_o      <= SILENCE;
            clip_l_o       <= 1'b0;
            clip_r_o       <= 1'b0;
            sample_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            sample_valid_o <= 1'b0;
            if (sample_strobe_i && state_q != S_IDLE)
                overrun_o <= 1'b1;
            else if (overrun_clr_i)
                overrun_o <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (sample_strobe_i) begin
                        snap_l_q    <= ch_l_i;
                        snap_r_q    <= ch_r_i;
                        snap_g_q    <= gain_i;
                        snap_mute_q <= mute_i;
                        acc_l_q     <= '0;
                        acc_r_q     <= '0;
                        idx_q       <= '0;
                    end
                end
                S_ACCUM: begin
                    acc_l_q <= acc_l_q + ACC_W'(prod_l);
                    acc_r_q <= acc_r_q + ACC_W'(prod_r);
                    if (idx_q != LAST) idx_q <= idx_q + 1'b1;
                end
                S_OUT: begin
                    audio_l_o      <= out_l;
                    audio_r_o      <= out_r;
                    clip_l_o       <= clip_l;
                    clip_r_o       <= clip_r;
                    sample_valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_audio_mixer.sv
// Directed-vector bench for audio_mixer: mix table, overrun,
// async reset abort and signed-output mode.
module tb_audio_mixer;

    logic        clk;
    logic        rst_n;
    logic        strobe;
    logic [63:0] ch_l, ch_r;
    logic [31:0] gain;
    logic        mute;
    logic        oclr;

    logic [15:0] l_o, r_o, sl_o, sr_o;
    logic        valid, clip_l, clip_r, busy, ovr;
    logic        s_valid, s_clip_l, s_clip_r, s_busy, s_ovr;

    int nerr = 0;
    int nchk = 0;

    audio_mixer dut (
        .clk(clk), .rst_n(rst_n), .sample_strobe_i(strobe),
        .ch_l_i(ch_l), .ch_r_i(ch_r), .gain_i(gain), .mute_i(mute),
        .overrun_clr_i(oclr), .audio_l_o(l_o), .audio_r_o(r_o),
        .sample_valid_o(valid), .clip_l_o(clip_l), .clip_r_o(clip_r),
        .busy_o(busy), .overrun_o(ovr)
    );

    audio_mixer #(.CH_SIGNED(4'hF), .OUT_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .sample_strobe_i(strobe),
        .ch_l_i(ch_l), .ch_r_i(ch_r), .gain_i(gain), .mute_i(mute),
        .overrun_clr_i(oclr), .audio_l_o(sl_o), .audio_r_o(sr_o),
        .sample_valid_o(s_valid), .clip_l_o(s_clip_l), .clip_r_o(s_clip_r),
        .busy_o(s_busy), .overrun_o(s_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] l;
        logic [63:0] r;
        logic [31:0] g;
        logic        m;
        logic [15:0] el;
        logic [15:0] er;
        logic        cl;
        logic        cr;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_mix(input logic [63:0] l, input logic [63:0] r,
                          input logic [31:0] g, input logic m);
        int lat;
        ch_l   = l;
        ch_r   = r;
        gain   = g;
        mute   = m;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        ch_l   = {$urandom, $urandom};
        ch_r   = {$urandom, $urandom};
        gain   = $urandom;
        mute   = 1'($urandom_range(0, 1));
        check("busy_after_strobe", 32'(busy), 32'd1);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (valid) begin
                lat = c;
                break;
            end
        end
        check("latency", 32'(lat), 32'd5);
        check("busy_at_valid", 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{"unity", 64'h0000_0000_0000_C000, 64'h0000_0000_0000_C000,
                    32'h0000_0080, 1'b0, 16'hC000, 16'hC000, 1'b0, 1'b0};
        vecs[1] = '{"halfmix", 64'h0000_0000_6000_C000, 64'h0000_0000_6000_C000,
                    32'h0000_8040, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0};
        vecs[2] = '{"saturate", 64'h0000_0000_F000_F000, 64'h0000_0000_1000_1000,
                    32'h0000_8080, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{"mute", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    32'hFFFF_FFFF, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0};
        vecs[4] = '{"four_ch", 64'h9000_9000_9000_9000, 64'h7000_7000_7000_7000,
                    32'h8080_8080, 1'b0, 16'hC000, 16'h4000, 1'b0, 1'b0};
        vecs[5] = '{"floor_g255", 64'h0000_0000_0000_8001, 64'h0000_0000_0000_7FFF,
                    32'h0000_00FF, 1'b0, 16'h8001, 16'h7FFE, 1'b0, 1'b0};
        vecs[6] = '{"full_noclip", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0000,
                    32'h0000_0080, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};

        rst_n  = 1'b0;
        strobe = 1'b0;
        ch_l   = '0;
        ch_r   = '0;
        gain   = '0;
        mute   = 1'b0;
        oclr   = 1'b0;
        tick();
        tick();
        check("rst_l", 32'(l_o), 32'h8000);
        check("rst_r", 32'(r_o), 32'h8000);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_clip", 32'({clip_l, clip_r}), 32'd0);
        check("rst_s_l", 32'(sl_o), 32'h0000);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_mix(vecs[i].l, vecs[i].r, vecs[i].g, vecs[i].m);
            check({vecs[i].name, "_l"}, 32'(l_o), 32'(vecs[i].el));
            check({vecs[i].name, "_r"}, 32'(r_o), 32'(vecs[i].er));
            check({vecs[i].name, "_clip_l"}, 32'(clip_l), 32'(vecs[i].cl));
            check({vecs[i].name, "_clip_r"}, 32'(clip_r), 32'(vecs[i].cr));
            tick();
            check({vecs[i].name, "_pulse"}, 32'(valid), 32'd0);
            tick();
            check({vecs[i].name, "_hold"}, 32'(l_o), 32'(vecs[i].el));
        end

        // signed output, signed channels: -1 * 255 floors to -2
        do_mix(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 32'h0000_00FF, 1'b0);
        check("signed_l", 32'(sl_o), 32'h0000_FFFE);
        check("signed_r", 32'(sr_o), 32'h0000_0001);
        check("signed_clip", 32'({s_clip_l, s_clip_r}), 32'd0);
        check("signed_valid", 32'(s_valid), 32'd1);
        tick();

        // overrun: second strobe at k+2 ignored, k+6 accepted
        ch_l   = vecs[0].l;
        ch_r   = vecs[0].r;
        gain   = vecs[0].g;
        mute   = 1'b0;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        ch_l   = vecs[2].l;
        ch_r   = vecs[2].r;
        gain   = vecs[2].g;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("ovr_set", 32'(ovr), 32'd1);
        tick();
        tick();
        check("ovr_no_early_valid", 32'(valid), 32'd0);
        tick();
        check("ovr_valid_k5", 32'(valid), 32'd1);
        check("ovr_first_l", 32'(l_o), 32'hC000);
        check("ovr_first_r", 32'(r_o), 32'hC000);
        check("ovr_sticky", 32'(ovr), 32'd1);
        strobe = 1'b1;
        tick();
        check("ovr_k6_accept", 32'(busy), 32'd1);
        oclr = 1'b1;
        tick();
        check("ovr_new_wins", 32'(ovr), 32'd1);
        strobe = 1'b0;
        tick();
        oclr = 1'b0;
        check("ovr_cleared", 32'(ovr), 32'd0);
        tick();
        tick();
        tick();
        check("ovr_second_valid", 32'(valid), 32'd1);
        check("ovr_second_l", 32'(l_o), 32'hFFFF);
        check("ovr_second_r", 32'(r_o), 32'h0000);
        tick();

        // async reset mid-ACCUM aborts the mix
        do_mix(vecs[0].l, vecs[0].r, vecs[0].g, 1'b0);
        tick();
        ch_l   = vecs[2].l;
        ch_r   = vecs[2].r;
        gain   = vecs[2].g;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_l", 32'(l_o), 32'h8000);
        check("abort_r", 32'(r_o), 32'h8000);
        check("abort_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (valid) seen = 1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/audio_mixer.md
# audio_mixer

Parametrised N-channel stereo audio mixer for the `clk_pixel` audio domain. It sits between the card audio sources (SuperSprite, Mockingboard, Apple speaker, future cards) and `audio_out`. It replaces ad-hoc summing with per-channel gain, signed/unsigned input handling, saturation and clip/overrun reporting. Mixing is time-multiplexed: one multiply-accumulate per channel per clock, triggered by a sample strobe.

## Interface
- `NUM_CHANNELS`, 4: number of input channels, 1..16.
- `IN_WIDTH`, 16: input sample width, 8..24.
- `OUT_WIDTH`, 16: output width, ≥ `IN_WIDTH`.
- `CH_SIGNED`, 0: `NUM_CHANNELS`-bit mask; bit i=1 means channel i is two's complement, 0 means offset binary.
- `OUT_SIGNED`, 0: 1 = two's-complement output, 0 = offset binary (feeds `audio_out` with `is_signed=0`).

Ports:
- `clk`  in  1  mixer clock (`clk_pixel`).
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `sample_strobe_i`  in  1  start a mix; single-cycle pulse.
- `ch_l_i`  in  `NUM_CHANNELS*IN_WIDTH`  left samples; channel i at bits [i*IN_WIDTH +: IN_WIDTH].
- `ch_r_i`  in  `NUM_CHANNELS*IN_WIDTH`  right samples; same packing. Mono sources drive both.
- `gain_i`  in  `NUM_CHANNELS*8`  per-channel unsigned Q1.7 gain; 128 = unity, 255 ≈ 1.99.
- `mute_i`  in  1  force silence on output.
- `overrun_clr_i`  in  1  clear `overrun_o`.
- `audio_l_o`, `audio_r_o`  out  `OUT_WIDTH`  mixed samples.
- `sample_valid_o`  out  1  one-cycle pulse; outputs updated.
- `clip_l_o`, `clip_r_o`  out  1  saturation occurred on the current output; valid with the outputs.
- `busy_o`  out  1  mix in progress.
- `overrun_o`  out  1  sticky: a strobe arrived while busy.

## Operation
- States: IDLE, ACCUM, OUT.
- **IDLE**
  - On an edge with `sample_strobe_i`=1: snapshot `ch_l_i`, `ch_r_i`, `gain_i` and `mute_i`.
  - Clear both accumulators, set `idx`=0, go to ACCUM.
- **ACCUM**
  - Each edge: for both sides, `acc += conv(snap[idx]) * gain[idx]`, then `idx++`.
  - After the edge processing `idx = NUM_CHANNELS-1`, go to OUT.
- **OUT**
  - One edge: compute `r = acc >>> 7` (arithmetic, floor), then `r <<= OUT_WIDTH-IN_WIDTH`.
  - Saturate `r` to the signed `OUT_WIDTH` range and set `clip_*` if clamped.
  - If the snapshot mute is set, the result is 0 and clip is 0.
  - If `OUT_SIGNED`=0, invert the MSB.
  - Register outputs, pulse `sample_valid_o`, return to IDLE.
- Input conversion `conv`: signed channels are used as-is; unsigned channels get the MSB inverted and are then treated as signed.
- Widths:
  - Product: `IN_WIDTH+9` signed (gain is zero-extended).
  - Accumulator: `IN_WIDTH+9+clog2(NUM_CHANNELS)`; cannot overflow.
- Outputs hold between valid pulses; they are only written in OUT.
- Overrun:
  - A strobe in ACCUM or OUT is ignored and sets `overrun_o`.
  - The in-progress mix is unaffected.
  - `overrun_clr_i` clears `overrun_o`; a simultaneous new overrun wins (flag stays 1).
- Silence encoding: 0 when `OUT_SIGNED`=1, `1<<(OUT_WIDTH-1)` when `OUT_SIGNED`=0.

## Timing
- Reset values:
  - State IDLE, `idx`=0, accumulators 0.
  - `audio_l_o`/`audio_r_o` = silence encoding.
  - `sample_valid_o`, `clip_*`, `busy_o`, `overrun_o` = 0.
- Reset asserted mid-ACCUM or mid-OUT aborts the mix: no valid pulse, outputs return to silence.
- Latency: strobe sampled at edge k → `sample_valid_o` high in the cycle after edge k+N+1, where N=`NUM_CHANNELS`.
- `busy_o` is high from after edge k until after edge k+N+1, i.e. while in ACCUM or OUT.
- Minimum strobe spacing: N+2 cycles. The first strobe accepted after OUT is at edge k+N+2.
- Inputs only need to be stable at the strobe edge; later input changes do not affect the mix in progress.

## Test plan
All cases use N=4, IN=OUT=16, CH_SIGNED=0, OUT_SIGNED=0 unless noted.
- **Reset:** assert `rst_n`=0 asynchronously mid-ACCUM → outputs 16'h8000 immediately, `busy_o`=0, no `sample_valid_o` after release.
- **Unity, single channel:**
  - Stimulus: ch0 L=R=16'hC000, gain0=128, other gains 0; strobe at edge k.
  - Response: valid after edge k+5; L=R=16'hC000, clip=0.
- **Half gain and mix:**
  - Stimulus: ch0=16'hC000 with gain 64; ch1=16'h6000 with gain 128 → +0x2000 − 0x2000.
  - Response: out 16'h8000.
- **Saturation:**
  - Positive: ch0=ch1=16'hF000 at unity → L=16'hFFFF, `clip_l_o`=1.
  - Negative: ch0=ch1 R=16'h1000 → R=16'h0000, `clip_r_o`=1.
- **Overrun:** strobe at k and k+2 → one valid pulse after k+5 with the k-snapshot result; `overrun_o`=1 until `overrun_clr_i`. Strobe at k+6 is accepted normally.
- **Mute and signed mode:**
  - `mute_i`=1 at strobe with full-scale inputs → 16'h8000, clip=0.
  - OUT_SIGNED=1, CH_SIGNED=4'hF, ch0=16'hFFFF (−1), gain 255 → floor(−255/128) = −2 = 16'hFFFE.
